// File: rtl/router_pkt_tx_if.sv
// Bundle of the command, payload-load and router-side signals of the
// packet transmitter. The master modport is the transmitter's view. The
// slave modport is the view of whoever issues commands, supplies payload
// and plays the router.
interface router_pkt_tx_if;
    // command channel
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       corrupt_parity;
    logic       cmd_rdy;
    logic       cmd_err;

    // payload load channel
    logic [7:0] pl_data;
    logic       pl_vld;
    logic       pl_rdy;

    // router-side packet channel
    logic       busy;
    logic       pkt_vld;
    logic [7:0] data_out;
    logic       pkt_done;
    logic [15:0] pkt_cnt;

    modport master (
        input  start, dest_addr, pay_len, corrupt_parity,
        input  pl_data, pl_vld,
        input  busy,
        output cmd_rdy, cmd_err, pl_rdy,
        output pkt_vld, data_out, pkt_done, pkt_cnt
    );

    modport slave (
        output start, dest_addr, pay_len, corrupt_parity,
        output pl_data, pl_vld,
        output busy,
        input  cmd_rdy, cmd_err, pl_rdy,
        input  pkt_vld, data_out, pkt_done, pkt_cnt
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port. It takes a command
// (destination, length), buffers the whole payload, then sends header,
// payload and parity back to back. It holds the current byte while the
// router raises busy. Each completed packet is reported with a pulse and
// counted.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    router_pkt_tx_if.master bus
);

    // The gap counter runs 0..GAP_CYCLES-1, so it needs at least one bit.
    localparam int GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_e;

    state_e          state_q;
    logic [1:0]      dest_q;
    logic [5:0]      len_q;
    logic            corrupt_q;
    logic [5:0]      idx_q;
    logic [7:0]      parity_q;
    logic [GapW-1:0] gap_q;
    logic [7:0]      data_out_q;
    logic            pkt_vld_q;
    logic            pkt_done_q;
    logic            cmd_err_q;
    logic [15:0]     pkt_cnt_q;

    // The payload buffer has no reset. A packet cut short by reset is
    // abandoned, and every new packet overwrites the bytes it uses.
    logic [7:0]      payload_mem [64];

    logic [7:0]      rd_byte;
    logic [7:0]      parity_d;
    logic            cmd_illegal;

    // Next byte to present, running parity including the byte on the bus,
    // and the command legality check.
    always_comb begin
        rd_byte     = payload_mem[idx_q];
        parity_d    = parity_q ^ data_out_q;
        cmd_illegal = (bus.dest_addr == 2'd3) || (bus.pay_len == 6'd0);
    end

    // Payload capture: one byte per valid beat while loading.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && bus.pl_vld) begin
            payload_mem[idx_q] <= bus.pl_data;
        end
    end

    // Main sequencer. It owns every registered output. A byte on the bus
    // is accepted on any edge in HDR/PAYLOAD/PARITY with busy low.
    // Otherwise data_out and pkt_vld simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dest_q     <= 2'd0;
            len_q      <= 6'd0;
            corrupt_q  <= 1'b0;
            idx_q      <= 6'd0;
            parity_q   <= 8'h00;
            gap_q      <= '0;
            data_out_q <= 8'h00;
            pkt_vld_q  <= 1'b0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            cmd_err_q  <= 1'b0;
            pkt_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cmd_illegal) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            dest_q    <= bus.dest_addr;
                            len_q     <= bus.pay_len;
                            corrupt_q <= bus.corrupt_parity;
                            idx_q     <= 6'd0;
                            state_q   <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (bus.pl_vld) begin
                        if (idx_q == len_q - 6'd1) begin
                            data_out_q <= {len_q, dest_q};
                            pkt_vld_q  <= 1'b1;
                            idx_q      <= 6'd0;
                            parity_q   <= 8'h00;
                            state_q    <= S_HDR;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end

                S_HDR: begin
                    if (!bus.busy) begin
                        parity_q   <= parity_d;
                        data_out_q <= rd_byte;
                        idx_q      <= 6'd1;
                        state_q    <= S_PAYLOAD;
                    end
                end

                // idx_q always points one past the byte currently on the bus.
                // When it equals len_q the last payload byte is being accepted.
                S_PAYLOAD: begin
                    if (!bus.busy) begin
                        parity_q <= parity_d;
                        if (idx_q == len_q) begin
                            data_out_q <= parity_d ^ {7'd0, corrupt_q};
                            pkt_vld_q  <= 1'b0;
                            state_q    <= S_PARITY;
                        end else begin
                            data_out_q <= rd_byte;
                            idx_q      <= idx_q + 6'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (!bus.busy) begin
                        data_out_q <= 8'h00;
                        pkt_done_q <= 1'b1;
                        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        gap_q      <= '0;
                        state_q    <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_q == GapLast) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_rdy  = (state_q == S_IDLE);
    assign bus.pl_rdy   = (state_q == S_LOAD);
    assign bus.cmd_err  = cmd_err_q;
    assign bus.pkt_vld  = pkt_vld_q;
    assign bus.data_out = data_out_q;
    assign bus.pkt_done = pkt_done_q;
    assign bus.pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised, scoreboard-checked bench for router_pkt_tx. The stimulus
// process issues commands and payload and queues the expected router-side
// bytes. A separate monitor compares every byte the router would see.
module tb_router_pkt_tx;

    localparam int GapCycles = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       vld;
    } expByte_t;

    logic clk = 1'b0;
    logic rst;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.GAP_CYCLES(GapCycles)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    expByte_t   expQ [$];
    logic [7:0] payload [64];
    int         errCount   = 0;
    int         checkCount = 0;
    int         expCnt     = 0;
    bit         inPkt      = 1'b0;
    bit         doneDue    = 1'b0;

    // Compare one observed value against the value the bench requires.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Record a failure that has no value to compare (timeouts, stray bytes).
    task automatic failNow(input string name, input string got, input string req);
        checkCount++;
        errCount++;
        $display("[TB] FAIL %s: got %s, required %s at t=%0t", name, got, req, $time);
    endtask

    // Monitor: on every falling edge, look at the router side. While a packet
    // is in flight, the head of the queue must be on the bus. It is popped
    // when busy is low, because the next rising edge accepts it.
    initial begin : monitor
        expByte_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                inPkt   = 1'b0;
                doneDue = 1'b0;
                expCnt  = 0;
            end else begin
                if (doneDue) begin
                    checkOutput("pktDone", 32'(bus.pkt_done), 1);
                    checkOutput("pktCnt", 32'(bus.pkt_cnt), expCnt & 32'hFFFF);
                    doneDue = 1'b0;
                end else if (bus.pkt_done) begin
                    checkOutput("strayDone", 32'(bus.pkt_done), 0);
                end
                if (bus.pkt_vld && !inPkt) begin
                    inPkt = 1'b1;
                end
                if (inPkt) begin
                    if (expQ.size() == 0) begin
                        failNow("strayByte", "unexpected packet byte", "no packet");
                        inPkt = 1'b0;
                    end else begin
                        e = expQ[0];
                        checkOutput(bus.busy ? "heldByte" : "txByte", 32'(bus.data_out), 32'(e.data));
                        checkOutput(bus.busy ? "heldVld" : "txVld", 32'(bus.pkt_vld), 32'(e.vld));
                        if (!bus.busy) begin
                            void'(expQ.pop_front());
                            if (!e.vld) begin
                                inPkt   = 1'b0;
                                doneDue = 1'b1;
                                expCnt++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Send one legal packet using payload[0..len-1].
    // loadMode: 0 = continuous, 1 = pl_vld every other cycle, 2 = random gaps.
    // busyPct: random stall probability. stallIdx/stallLen: a forced stall on
    // the accept-th byte. resetAt: assert reset when that byte is presented
    // (-1 = never).
    task automatic applyStimulus(input logic [1:0] dest, input logic [5:0] len, input bit corrupt,
                                 input int loadMode, input int busyPct, input int stallIdx,
                                 input int stallLen, input int resetAt);
        logic [7:0] hdr;
        logic [7:0] par;
        int j;
        int acc;
        int guard;
        int stallLeft;

        hdr = {len, dest};
        par = hdr;
        expQ.push_back('{data: hdr, vld: 1'b1});
        for (int i = 0; i < int'(len); i++) begin
            expQ.push_back('{data: payload[i], vld: 1'b1});
            par = par ^ payload[i];
        end
        par[0] = par[0] ^ corrupt;
        expQ.push_back('{data: par, vld: 1'b0});

        // Command cycle. The junk payload beat alongside it must be ignored.
        bus.start          = 1'b1;
        bus.dest_addr      = dest;
        bus.pay_len        = len;
        bus.corrupt_parity = corrupt;
        bus.pl_vld         = 1'b1;
        bus.pl_data        = 8'hEE;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("plRdyAfterCmd", 32'(bus.pl_rdy), 1);
        checkOutput("cmdRdyInLoad", 32'(bus.cmd_rdy), 0);

        j     = 0;
        guard = 0;
        while (j < int'(len) && guard < 1000) begin
            checkOutput("vldInLoad", 32'(bus.pkt_vld), 0);
            case (loadMode)
                0:       bus.pl_vld = 1'b1;
                1:       bus.pl_vld = (guard % 2 == 0);
                default: bus.pl_vld = ($urandom_range(0, 2) != 0);
            endcase
            bus.pl_data = bus.pl_vld ? payload[j] : 8'($urandom);
            bus.busy    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus.pl_vld) j++;
            guard++;
        end
        if (guard >= 1000) failNow("loadTimeout", "load still running", "load complete");
        bus.pl_vld = 1'b0;
        bus.busy   = 1'b0;
        checkOutput("hdrAfterLoad", 32'(bus.pkt_vld), 1);
        checkOutput("plRdyAfterLoad", 32'(bus.pl_rdy), 0);

        acc       = 0;
        guard     = 0;
        stallLeft = stallLen;
        while (acc < int'(len) + 2 && guard < 2000) begin
            if (acc == resetAt) begin
                // Reset with a legal start alongside it. Reset must win.
                rst                = 1'b1;
                bus.start          = 1'b1;
                bus.dest_addr      = 2'd1;
                bus.pay_len        = 6'd4;
                bus.busy           = 1'b0;
                #1;
                checkOutput("rstPktVld", 32'(bus.pkt_vld), 0);
                checkOutput("rstDataOut", 32'(bus.data_out), 0);
                checkOutput("rstCmdRdy", 32'(bus.cmd_rdy), 1);
                checkOutput("rstPlRdy", 32'(bus.pl_rdy), 0);
                checkOutput("rstPktCnt", 32'(bus.pkt_cnt), 0);
                @(posedge clk); #1;
                rst       = 1'b0;
                bus.start = 1'b0;
                checkOutput("rstStartIgnored", 32'(bus.pl_rdy), 0);
                @(posedge clk); #1;
                checkOutput("cmdRdyAfterRst", 32'(bus.cmd_rdy), 1);
                checkOutput("pktCntAfterRst", 32'(bus.pkt_cnt), 0);
                return;
            end
            if (acc == stallIdx && stallLeft > 0) begin
                bus.busy = 1'b1;
                stallLeft--;
            end else begin
                bus.busy = ($urandom_range(0, 99) < busyPct);
            end
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.dest_addr = 2'($urandom_range(0, 2));
            bus.pay_len   = 6'($urandom_range(1, 63));
            bus.pl_vld    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (!bus.busy) acc++;
            guard++;
        end
        bus.start  = 1'b0;
        bus.pl_vld = 1'b0;
        bus.busy   = 1'b0;
        if (guard >= 2000) failNow("txTimeout", "packet still sending", "packet complete");

        checkOutput("cmdRdyGap", 32'(bus.cmd_rdy), 0);
        for (int k = 1; k <= GapCycles; k++) begin
            @(posedge clk); #1;
            checkOutput("cmdRdyAfterGap", 32'(bus.cmd_rdy), (k == GapCycles) ? 1 : 0);
        end
    endtask

    // Issue a command that must be rejected with a single cmd_err pulse.
    task automatic applyIllegal(input logic [1:0] dest, input logic [5:0] len);
        bus.start          = 1'b1;
        bus.dest_addr      = dest;
        bus.pay_len        = len;
        bus.corrupt_parity = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("cmdErrPulse", 32'(bus.cmd_err), 1);
        checkOutput("cmdRdyOnErr", 32'(bus.cmd_rdy), 1);
        checkOutput("plRdyOnErr", 32'(bus.pl_rdy), 0);
        @(posedge clk); #1;
        checkOutput("cmdErrCleared", 32'(bus.cmd_err), 0);
        checkOutput("plRdyStays0", 32'(bus.pl_rdy), 0);
        checkOutput("cntAfterErr", 32'(bus.pkt_cnt), expCnt & 32'hFFFF);
    endtask

    // Directed scenarios first, then randomised commands and traffic.
    initial begin : stimulus
        logic [1:0] rDest;
        logic [5:0] rLen;

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.dest_addr      = 2'd0;
        bus.pay_len        = 6'd0;
        bus.corrupt_parity = 1'b0;
        bus.pl_data        = 8'h00;
        bus.pl_vld         = 1'b0;
        bus.busy           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCmdRdy", 32'(bus.cmd_rdy), 1);
        checkOutput("resetCmdErr", 32'(bus.cmd_err), 0);
        checkOutput("resetPlRdy", 32'(bus.pl_rdy), 0);
        checkOutput("resetPktVld", 32'(bus.pkt_vld), 0);
        checkOutput("resetPktDone", 32'(bus.pkt_done), 0);
        checkOutput("resetDataOut", 32'(bus.data_out), 0);
        checkOutput("resetPktCnt", 32'(bus.pkt_cnt), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        payload[0] = 8'hA5;
        applyStimulus(2'd0, 6'd1, 1'b0, 0, 0, -1, 0, -1);

        payload[0] = 8'h11;
        payload[1] = 8'h22;
        payload[2] = 8'h33;
        applyStimulus(2'd2, 6'd3, 1'b0, 0, 0, 2, 3, -1);

        applyIllegal(2'd3, 6'd5);
        applyIllegal(2'd1, 6'd0);

        payload[0] = 8'hA5;
        applyStimulus(2'd0, 6'd1, 1'b1, 0, 0, -1, 0, -1);

        for (int i = 0; i < 63; i++) payload[i] = 8'($urandom);
        applyStimulus(2'd1, 6'd63, 1'b0, 1, 0, -1, 0, -1);

        for (int i = 0; i < 5; i++) payload[i] = 8'($urandom);
        applyStimulus(2'd2, 6'd5, 1'b0, 0, 0, -1, 0, 3);

        payload[0] = 8'hA5;
        applyStimulus(2'd0, 6'd1, 1'b0, 0, 0, -1, 0, -1);

        for (int n = 0; n < 24; n++) begin
            rDest = 2'($urandom_range(0, 3));
            rLen  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            if (rDest == 2'd3 || rLen == 6'd0) begin
                applyIllegal(rDest, rLen);
            end else begin
                for (int i = 0; i < 64; i++) payload[i] = 8'($urandom);
                applyStimulus(rDest, rLen, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                              $urandom_range(0, 50), -1, 0, -1);
            end
        end

        @(posedge clk); #1;
        checkOutput("queueDrained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Hard stop in case the design wedges the handshake.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before t=%0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
